// File: rtl/fir_seq_ctrl.sv
// Sequencing controller for the FIR band filters and the shared circular sample queue.
// Define FIR_SEQ_RUN_CNT_EN to add run_cnt_o, a saturating count of completed passes.
module fir_seq_ctrl #(
   parameter int unsigned NUM_TAPS = 1021,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned ROM_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              new_smpl_i,
   input  logic              clr_ovr_i,
   output logic              wrt_en_o,
   output logic [ADDR_W-1:0] wrt_ptr_o,
   output logic [ADDR_W-1:0] rd_ptr_o,
   output logic              sequencing_o,
   output logic              busy_o,
   output logic              filled_o,
   output logic              smpl_out_vld_o,
`ifdef FIR_SEQ_RUN_CNT_EN
   output logic [15:0]       run_cnt_o,
`endif
   output logic              overrun_o
);

   localparam int unsigned TapW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int unsigned FillW = $clog2(NUM_TAPS + 1);
   localparam int unsigned DrnW  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

   localparam logic [TapW-1:0]   LastTap = TapW'(NUM_TAPS - 1);
   localparam logic [FillW-1:0]  FillMax = FillW'(NUM_TAPS);
   localparam logic [DrnW-1:0]   LastDrn = DrnW'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);
   // Offset from the slot being written back to the oldest sample of the window.
   localparam logic [ADDR_W-1:0] WinOffs = ADDR_W'((2 ** ADDR_W) + 1 - NUM_TAPS);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e             state_q;
   logic [ADDR_W-1:0]  wrt_ptr_q, rd_ptr_q;
   logic [FillW-1:0]   fill_cnt_q, fill_cnt_d;
   logic [TapW-1:0]    tap_cnt_q;
   logic [DrnW-1:0]    drain_cnt_q;
   logic               seq_q, busy_q, filled_q, vld_q, ovr_q;
   logic               launch;

   always_comb begin
      fill_cnt_d = fill_cnt_q;
      if (new_smpl_i && (fill_cnt_q != FillMax)) begin
         fill_cnt_d = fill_cnt_q + 1'b1;
      end
   end

   // The launching sample itself counts toward a full window.
   assign launch = new_smpl_i && (state_q == StIdle) && (fill_cnt_d == FillMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrt_ptr_q  <= '0;
         fill_cnt_q <= '0;
         filled_q   <= 1'b0;
      end else begin
         if (new_smpl_i) begin
            wrt_ptr_q <= wrt_ptr_q + 1'b1;
         end
         fill_cnt_q <= fill_cnt_d;
         filled_q   <= (fill_cnt_d == FillMax);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rd_ptr_q    <= '0;
         tap_cnt_q   <= '0;
         drain_cnt_q <= '0;
         seq_q       <= 1'b0;
         busy_q      <= 1'b0;
         vld_q       <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (launch) begin
                  state_q   <= StRun;
                  rd_ptr_q  <= wrt_ptr_q + WinOffs;
                  tap_cnt_q <= '0;
                  seq_q     <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            StRun: begin
               rd_ptr_q  <= rd_ptr_q + 1'b1;
               tap_cnt_q <= tap_cnt_q + 1'b1;
               if (tap_cnt_q == LastTap) begin
                  seq_q <= 1'b0;
                  if (ROM_LAT == 0) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     vld_q   <= 1'b1;
                  end else begin
                     state_q     <= StDrain;
                     drain_cnt_q <= '0;
                  end
               end
            end
            StDrain: begin
               drain_cnt_q <= drain_cnt_q + 1'b1;
               if (drain_cnt_q == LastDrn) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  vld_q   <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // A set in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= 1'b0;
      end else if (new_smpl_i && busy_q) begin
         ovr_q <= 1'b1;
      end else if (clr_ovr_i) begin
         ovr_q <= 1'b0;
      end
   end

`ifdef FIR_SEQ_RUN_CNT_EN
   logic [15:0] run_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_q <= '0;
      end else if (clr_ovr_i) begin
         run_cnt_q <= '0;
      end else if (vld_q && (run_cnt_q != 16'hFFFF)) begin
         run_cnt_q <= run_cnt_q + 1'b1;
      end
   end

   assign run_cnt_o = run_cnt_q;
`endif

   assign wrt_en_o       = new_smpl_i;
   assign wrt_ptr_o      = wrt_ptr_q;
   assign rd_ptr_o       = rd_ptr_q;
   assign sequencing_o   = seq_q;
   assign busy_o         = busy_q;
   assign filled_o       = filled_q;
   assign smpl_out_vld_o = vld_q;
   assign overrun_o      = ovr_q;

endmodule
